// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   Universal shift register for the stepper datapath. It can hold, shift up or
//   down, rotate, or parallel-load. A counted burst engine runs N operations from
//   a single start pulse and reports progress with busy/done.
//
//   Build option ROTATE_EN:
//     defined   - modes 011/100 rotate the register.
//     undefined - modes 011/100 act as shift up/down, so data enters the
//                 register; no rotate path is built.
//
// Ports
//   clk       in   1      rising-edge clock
//   clr_n     in   1      asynchronous active-low reset
//   clr       in   1      synchronous clear; highest synchronous priority, ignores ce
//   ce        in   1      clock enable for register operations
//   mode      in   3      000 hold, 001 shl, 010 shr, 011 rol, 100 ror, 101 load, 11x hold
//   data      in   1      serial input for shifts (sampled live, also during bursts)
//   load_val  in   WIDTH  parallel load value
//   start     in   1      burst request, accepted in IDLE only
//   count     in   CNT_W  burst length, captured with start
//   q         out  WIDTH  register contents
//   sout      out  1      last bit shifted/rotated out (registered)
//   busy      out  1      burst in progress
//   done      out  1      one-cycle pulse after the final burst edge
//   fsm_state out  1      debug view of the burst FSM (0 IDLE, 1 RUN)
//
// Handshake: start is accepted on any edge in IDLE, and ce is not required.
// busy rises on that edge. Each later edge with ce=1 performs one latched
// operation. The edge that performs the last operation drops busy and raises
// done for one cycle. A start still held high is accepted again on the next edge.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             ce,
  input  logic [2:0]       mode,
  input  logic             data,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             fsm_state
);

  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state, nxt_state;
  logic [2:0]       op_mode, nxt_mode;
  logic [CNT_W-1:0] remaining, nxt_rem;
  logic             nxt_done;
  logic             do_op;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] op_q;
  logic             op_sout;

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= S_IDLE;
    else        state <= nxt_state;
  end

  // Next-state logic. It also decides whether this edge performs an operation
  // and which mode that operation uses.
  always_comb begin
    nxt_state = state;
    nxt_mode  = op_mode;
    nxt_rem   = remaining;
    nxt_done  = 1'b0;
    do_op     = 1'b0;
    op_sel    = mode;
    if (clr) begin
      nxt_state = S_IDLE;
      nxt_mode  = 3'b000;
      nxt_rem   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            nxt_state = S_RUN;
            nxt_mode  = mode;
            nxt_rem   = count;
          end else if (ce) begin
            do_op = 1'b1;
          end
        end
        S_RUN: begin
          op_sel = op_mode;
          if (remaining == '0) begin
            // A zero-length burst completes on the next edge, whatever ce is.
            nxt_state = S_IDLE;
            nxt_done  = 1'b1;
          end else if (ce) begin
            do_op   = 1'b1;
            nxt_rem = remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              nxt_state = S_IDLE;
              nxt_done  = 1'b1;
            end
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy      = (state == S_RUN);
    fsm_state = state;
  end

  // Burst bookkeeping registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_mode   <= 3'b000;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      op_mode   <= nxt_mode;
      remaining <= nxt_rem;
      done      <= nxt_done;
    end
  end

  // Operation result for the selected mode
  always_comb begin
    op_q    = q;
    op_sout = sout;
    case (op_sel)
      M_SHL: begin
        op_q    = {q[WIDTH-2:0], data};
        op_sout = q[WIDTH-1];
      end
      M_SHR: begin
        op_q    = {data, q[WIDTH-1:1]};
        op_sout = q[0];
      end
      M_ROL: begin
`ifdef ROTATE_EN
        op_q    = {q[WIDTH-2:0], q[WIDTH-1]};
`else
        op_q    = {q[WIDTH-2:0], data};
`endif
        op_sout = q[WIDTH-1];
      end
      M_ROR: begin
`ifdef ROTATE_EN
        op_q    = {q[0], q[WIDTH-1:1]};
`else
        op_q    = {data, q[WIDTH-1:1]};
`endif
        op_sout = q[0];
      end
      M_LOAD: op_q = load_val;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q    <= '0;
      sout <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      sout <= 1'b0;
    end else if (do_op) begin
      q    <= op_q;
      sout <= op_sout;
    end
  end

endmodule
